// File: rtl/ste_io_slave_if.sv
// STEbus I/O slave bus bundle: address, command, strobe, data and acknowledge.
// The master modport drives the cycle; the slave modport answers it.
interface ste_io_slave_if #(
  parameter int ADR_W = 12
);
  logic [ADR_W-1:0] adr;
  logic [2:0]       cm;
  logic             strobe_n;
  logic [7:0]       dat_in;
  logic [7:0]       dat_out;
  logic             dat_oe;
  logic             datack_n;
  logic             trferr_n;

  modport master (
    output adr,
    output cm,
    output strobe_n,
    output dat_in,
    input  dat_out,
    input  dat_oe,
    input  datack_n,
    input  trferr_n
  );

  modport slave (
    input  adr,
    input  cm,
    input  strobe_n,
    input  dat_in,
    output dat_out,
    output dat_oe,
    output datack_n,
    output trferr_n
  );
endinterface

// File: rtl/ste_io_slave.sv
// STEbus I/O slave: 4 r/w registers plus an ID byte in an 8-byte window.
// Define STE_IO_SLAVE_TRFERR_EN to answer offsets 5..7 with TRFERR*.
module ste_io_slave #(
  parameter int               ADR_W       = 12,
  parameter logic [ADR_W-1:0] BASE_ADR    = ADR_W'(12'h100),
  parameter int               WAIT_CYCLES = 2,
  parameter logic [7:0]       ID_VALUE    = 8'h5A
) (
  input  logic              clk,
  input  logic              rst_n,
  ste_io_slave_if.slave     bus,
  output logic [7:0]        ctrl_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_REL
  } state_e;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_e          state_q, state_d;
  logic            s1_q, s1_d;
  logic            s2_q, s2_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [2:0]      off_q, off_d;
  logic            rd_q, rd_d;
  logic [7:0]      wdat_q, wdat_d;
  logic [3:0][7:0] regs_q, regs_d;
  logic [7:0]      dat_out_q, dat_out_d;
  logic            dat_oe_q, dat_oe_d;
  logic            datack_n_q, datack_n_d;
  logic            trferr_n_q, trferr_n_d;

  logic            sel;
  logic            cyc_rd;
  logic            cyc_wr;
  logic            ack_go;
  logic [2:0]      ack_off;
  logic            ack_rd;
  logic [7:0]      ack_wdat;

  function automatic logic [7:0] rd_mux(
    input logic [2:0]      off,
    input logic [3:0][7:0] regs
  );
    logic [7:0] r;
    unique case (1'b1)
      !off[2]:       r = regs[off[1:0]];
      off == 3'd4:   r = ID_VALUE;
      default:       r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic err_off(input logic [2:0] off);
`ifdef STE_IO_SLAVE_TRFERR_EN
    return off[2] & (off[1] | off[0]);
`else
    return 1'b0 & off[0];
`endif
  endfunction

  assign sel    = bus.adr[ADR_W-1:3] == BASE_ADR[ADR_W-1:3];
  assign cyc_rd = bus.cm == 3'b101;
  assign cyc_wr = bus.cm == 3'b100;

  always_comb begin
    state_d    = state_q;
    s1_d       = bus.strobe_n;
    s2_d       = s1_q;
    cnt_d      = cnt_q;
    off_d      = off_q;
    rd_d       = rd_q;
    wdat_d     = wdat_q;
    regs_d     = regs_q;
    dat_out_d  = dat_out_q;
    dat_oe_d   = dat_oe_q;
    datack_n_d = datack_n_q;
    trferr_n_d = trferr_n_q;
    ack_go     = 1'b0;
    ack_off    = off_q;
    ack_rd     = rd_q;
    ack_wdat   = wdat_q;

    unique case (state_q)
      S_IDLE: begin
        if (!s2_q && sel && (cyc_rd || cyc_wr)) begin
          off_d     = bus.adr[2:0];
          rd_d      = cyc_rd;
          wdat_d    = bus.dat_in;
          cnt_d     = WAIT_LD;
          dat_oe_d  = cyc_rd;
          dat_out_d = cyc_rd ? rd_mux(bus.adr[2:0], regs_q) : 8'h00;
          if (WAIT_CYCLES == 0) begin
            // No wait states: acknowledge straight from the capture edge
            state_d  = S_ACK;
            ack_go   = 1'b1;
            ack_off  = bus.adr[2:0];
            ack_rd   = cyc_rd;
            ack_wdat = bus.dat_in;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (s2_q) begin
          state_d   = S_IDLE;
          dat_oe_d  = 1'b0;
          dat_out_d = 8'h00;
        end else if (cnt_q == 4'd0) begin
          state_d = S_ACK;
          ack_go  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK: begin
        if (s2_q) begin
          state_d    = S_REL;
          datack_n_d = 1'b1;
          trferr_n_d = 1'b1;
          dat_oe_d   = 1'b0;
          dat_out_d  = 8'h00;
        end
      end
      S_REL: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (ack_go) begin
      if (err_off(ack_off)) begin
        trferr_n_d = 1'b0;
      end else begin
        datack_n_d = 1'b0;
      end
      if (!ack_rd && !ack_off[2]) begin
        regs_d[ack_off[1:0]] = ack_wdat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      s1_q       <= 1'b1;
      s2_q       <= 1'b1;
      cnt_q      <= 4'd0;
      off_q      <= 3'd0;
      rd_q       <= 1'b0;
      wdat_q     <= 8'h00;
      regs_q     <= '0;
      dat_out_q  <= 8'h00;
      dat_oe_q   <= 1'b0;
      datack_n_q <= 1'b1;
      trferr_n_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      cnt_q      <= cnt_d;
      off_q      <= off_d;
      rd_q       <= rd_d;
      wdat_q     <= wdat_d;
      regs_q     <= regs_d;
      dat_out_q  <= dat_out_d;
      dat_oe_q   <= dat_oe_d;
      datack_n_q <= datack_n_d;
      trferr_n_q <= trferr_n_d;
    end
  end

  assign bus.dat_out  = dat_out_q;
  assign bus.dat_oe   = dat_oe_q;
  assign bus.datack_n = datack_n_q;
  assign bus.trferr_n = trferr_n_q;
  assign ctrl_out     = regs_q[0];

endmodule

// File: tb/tb_ste_io_slave.sv
// Directed bench for ste_io_slave: two instances (2 and 4 wait states),
// expected acknowledge results queued at drive time and checked on ack.
module tb_ste_io_slave;

`ifdef STE_IO_SLAVE_TRFERR_EN
  localparam bit TRF = 1'b1;
`else
  localparam bit TRF = 1'b0;
`endif

  typedef struct {
    logic       oe;
    logic [7:0] data;
    logic       err;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [11:0] adr;
  logic [2:0]  cm;
  logic        strobe_n;
  logic [7:0]  dat_in;
  logic        use4;
  logic [7:0]  ctrl_a;
  logic [7:0]  ctrl_b;

  logic        o_datack;
  logic        o_trferr;
  logic        o_oe;
  logic [7:0]  o_dat;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  ste_io_slave_if #(.ADR_W(12)) bus_a ();
  ste_io_slave_if #(.ADR_W(12)) bus_b ();

  assign bus_a.adr      = adr;
  assign bus_a.cm       = cm;
  assign bus_a.dat_in   = dat_in;
  assign bus_a.strobe_n = use4 ? 1'b1 : strobe_n;
  assign bus_b.adr      = adr;
  assign bus_b.cm       = cm;
  assign bus_b.dat_in   = dat_in;
  assign bus_b.strobe_n = use4 ? strobe_n : 1'b1;

  assign o_datack = use4 ? bus_b.datack_n : bus_a.datack_n;
  assign o_trferr = use4 ? bus_b.trferr_n : bus_a.trferr_n;
  assign o_oe     = use4 ? bus_b.dat_oe   : bus_a.dat_oe;
  assign o_dat    = use4 ? bus_b.dat_out  : bus_a.dat_out;

  ste_io_slave #(.WAIT_CYCLES(2)) u_dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus_a),
    .ctrl_out (ctrl_a)
  );

  ste_io_slave #(.WAIT_CYCLES(4)) u_dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus_b),
    .ctrl_out (ctrl_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [11:0] a, input logic [2:0] c,
                       input logic [7:0] d);
    @(negedge clk);
    adr      = a;
    cm       = c;
    dat_in   = d;
    strobe_n = 1'b0;
  endtask

  task automatic push(input logic oe, input logic [7:0] d, input logic e);
    exp_t x;
    x.oe   = oe;
    x.data = d;
    x.err  = e;
    sb.push_back(x);
  endtask

  task automatic wait_ack(input string tag, input int exp_edges);
    int   n;
    bit   got;
    exp_t e;
    n   = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (o_datack === 1'b0 || o_trferr === 1'b0) got = 1'b1;
    end
    checks++;
    assert (got) else begin
      errors++;
      $error("FAIL %s ack: observed none after %0d edges expected ack",
             tag, n);
    end
    if (!got) return;
    if (exp_edges > 0) chk({tag, " latency"}, n, exp_edges);
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL %s scoreboard: observed empty queue expected entry", tag);
    end
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({tag, " ack/err"}, {o_datack, o_trferr}, e.err ? 2'b10 : 2'b01);
    chk({tag, " oe"}, o_oe, e.oe);
    if (e.oe) chk({tag, " data"}, o_dat, e.data);
  endtask

  task automatic release_strobe(input string tag);
    int n;
    bit done;
    @(negedge clk);
    strobe_n = 1'b1;
    n    = 0;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (o_datack === 1'b1 && o_trferr === 1'b1) done = 1'b1;
    end
    checks++;
    assert (done && n >= 2 && n <= 3) else begin
      errors++;
      $error("FAIL %s release: observed %0d edges expected 2..3", tag, n);
    end
    chk({tag, " oe off"}, o_oe, 1'b0);
    repeat (2) @(posedge clk);
  endtask

  task automatic expect_silent(input string tag, input int n,
                               input bit raise);
    bit bad;
    bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (o_datack !== 1'b1 || o_trferr !== 1'b1 || o_oe !== 1'b0)
        bad = 1'b1;
    end
    checks++;
    assert (!bad) else begin
      errors++;
      $error("FAIL %s silent: observed bus activity expected none", tag);
    end
    if (raise) begin
      @(negedge clk);
      strobe_n = 1'b1;
    end
    repeat (4) @(posedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    strobe_n = 1'b0;
    adr      = 12'h100;
    cm       = 3'b101;
    dat_in   = 8'h00;
    use4     = 1'b0;

    // reset held with strobe low
    @(posedge clk);
    #1;
    chk("rst e1", {o_datack, o_trferr, o_oe, ctrl_a}, 11'h600);
    @(posedge clk);
    #1;
    chk("rst e2", {o_datack, o_trferr, o_oe, ctrl_a}, 11'h600);
    chk("rst dat", o_dat, 8'h00);
    @(negedge clk);
    rst_n    = 1'b1;
    strobe_n = 1'b1;
    repeat (3) @(posedge clk);

    // write then read back
    start(12'h100, 3'b100, 8'hA5);
    push(1'b0, 8'h00, 1'b0);
    wait_ack("wr0", 6);
    chk("wr0 ctrl", ctrl_a, 8'hA5);
    release_strobe("wr0");

    start(12'h100, 3'b101, 8'h00);
    push(1'b1, 8'hA5, 1'b0);
    wait_ack("rd0", 6);
    release_strobe("rd0");

    start(12'h104, 3'b101, 8'h00);
    push(1'b1, 8'h5A, 1'b0);
    wait_ack("rd id", 6);
    release_strobe("rd id");

    start(12'h106, 3'b101, 8'h00);
    push(1'b1, 8'h00, TRF);
    wait_ack("rd6", 6);
    release_strobe("rd6");

    start(12'h105, 3'b100, 8'hFF);
    push(1'b0, 8'h00, TRF);
    wait_ack("wr5", 6);
    release_strobe("wr5");

    // not selected / not an I/O cycle
    start(12'h108, 3'b100, 8'h33);
    expect_silent("nosel", 12, 1'b1);
    start(12'h100, 3'b110, 8'h44);
    expect_silent("mem cm", 12, 1'b1);
    chk("ctrl kept", ctrl_a, 8'hA5);

    // back-to-back writes with a one-clock strobe gap
    start(12'h102, 3'b100, 8'h11);
    push(1'b0, 8'h00, 1'b0);
    wait_ack("b2b1", 6);
    @(negedge clk);
    strobe_n = 1'b1;
    start(12'h103, 3'b100, 8'h22);
    push(1'b0, 8'h00, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("b2b1 released", o_datack, 1'b1);
    wait_ack("b2b2", -1);
    release_strobe("b2b2");

    start(12'h102, 3'b101, 8'h00);
    push(1'b1, 8'h11, 1'b0);
    wait_ack("rd2", 6);
    release_strobe("rd2");
    start(12'h103, 3'b101, 8'h00);
    push(1'b1, 8'h22, 1'b0);
    wait_ack("rd3", 6);
    release_strobe("rd3");

    // master abort on the 4-wait instance
    @(negedge clk);
    use4 = 1'b1;
    start(12'h101, 3'b100, 8'h77);
    repeat (4) @(posedge clk);
    @(negedge clk);
    strobe_n = 1'b1;
    expect_silent("abort", 14, 1'b0);
    start(12'h101, 3'b101, 8'h00);
    push(1'b1, 8'h00, 1'b0);
    wait_ack("abort rd1", 8);
    release_strobe("abort rd1");
    chk("b ctrl", ctrl_b, 8'h00);
    @(negedge clk);
    use4 = 1'b0;

    // reset during ACK
    start(12'h101, 3'b100, 8'h5C);
    push(1'b0, 8'h00, 1'b0);
    wait_ack("wr1", 6);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst ack", {o_datack, o_trferr, o_oe}, 3'b110);
    chk("rst ctrl", ctrl_a, 8'h00);
    @(negedge clk);
    rst_n    = 1'b1;
    strobe_n = 1'b1;
    repeat (4) @(posedge clk);

    start(12'h101, 3'b101, 8'h00);
    push(1'b1, 8'h00, 1'b0);
    wait_ack("rd1 post rst", 6);
    release_strobe("rd1 post rst");

    chk("sb drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
